ripple_carry_adder: RTL and testbench



---
 rtl/ripple_carry_adder.sv | 53 +++++
 tb/tb_ripple_carry_adder.sv | 136 +++++++++++++
 2 files changed

// File: rtl/ripple_carry_adder.sv
// Registered unsigned adder built from a structural chain of one-bit full-adder cells.
// The carry ripples from bit 0 to the MSB, and the result is registered for one cycle of latency.

module ripple_carry_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);
endmodule

module ripple_carry_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    // No carry-in port: the chain always starts from zero.
    assign c[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        ripple_carry_adder_cell u_cell (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            sum  <= s;
            cout <= c[WIDTH];
        end
    end
endmodule

// File: tb/tb_ripple_carry_adder.sv
// Self-checking bench: a 4-bit and an 8-bit adder are checked every cycle against an arithmetic model,
// and a set of literal expectations pins down both the model and the directed cases.

module tb_ripple_carry_adder;
    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] sum;
    logic       cout;
    logic [7:0] a8;
    logic [7:0] b8;
    logic [7:0] sum8;
    logic       cout8;

    int checks = 0;
    int errors = 0;
    bit check_en = 0;

    logic [4:0] exp4;
    logic [8:0] exp8;

    ripple_carry_adder #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .sum(sum), .cout(cout)
    );

    ripple_carry_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .sum(sum8), .cout(cout8)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // The reference model: the result of the operands seen at the last edge, or 0 while in reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp4 <= '0;
            exp8 <= '0;
        end else begin
            exp4 <= 5'(a) + 5'(b);
            exp8 <= 9'(a8) + 9'(b8);
        end
    end

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("model4", 9'({cout, sum}), 9'(exp4));
            chk("model8", {cout8, sum8}, exp8);
        end
    end

    // Operands are driven just after an edge; the result is checked just after the following edge.
    task automatic step(input logic [3:0] x, input logic [3:0] y, input logic [8:0] req, input string name);
        a = x;
        b = y;
        @(posedge clk);
        #1 chk(name, 9'({cout, sum}), req);
    endtask

    initial begin
        rst_n = 0;
        a = 4'd5;
        b = 4'd3;
        a8 = 8'hFF;
        b8 = 8'h01;
        #2 chk("async_reset_init", 9'({cout, sum}), 9'd0);
        repeat (3) begin
            @(posedge clk);
            #1 chk("held_in_reset", 9'({cout, sum}), 9'd0);
            chk("held_in_reset8", {cout8, sum8}, 9'd0);
        end
        @(negedge clk);
        rst_n = 1;
        #1 chk("before_first_edge", 9'({cout, sum}), 9'd0);
        @(posedge clk);
        #1 chk("first_after_reset", 9'({cout, sum}), 9'd8);
        chk("w8_ff_plus_1", {cout8, sum8}, 9'h100);
        check_en = 1;

        for (int i = 0; i < 256; i++) begin
            a = 4'(i >> 4);
            b = 4'(i);
            a8 = 8'($urandom_range(0, 255));
            b8 = 8'($urandom_range(0, 255));
            @(posedge clk);
            #1;
        end

        step(4'b1111, 4'b0001, 9'h10, "carry_15_1");
        step(4'b1111, 4'b1111, 9'h1E, "carry_15_15");
        step(4'd0, 4'd0, 9'h00, "zero_zero");
        step(4'd8, 4'd8, 9'h10, "msb_8_8");

        step(4'd9, 4'd9, 9'h12, "pre_midreset");
        #2 rst_n = 0;
        #1 chk("midreset_drop", 9'({cout, sum}), 9'd0);
        chk("midreset_drop8", 9'(cout8), 9'd0);
        #1 rst_n = 1;
        @(posedge clk);
        #1 chk("midreset_restore", 9'({cout, sum}), 9'h12);

        step(4'd3, 4'd4, 9'd7, "capture_3_4");
        #5 a = 4'd10;
        #1 chk("hold_between_edges", 9'({cout, sum}), 9'd7);
        @(posedge clk);
        #1 chk("after_change", 9'({cout, sum}), 9'd14);

        for (int i = 0; i < 64; i++) begin
            a = 4'($urandom);
            b = 4'($urandom);
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check_en = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running required finished");
        $fatal(1, "timeout");
    end
endmodule
